// File: rtl/test_image_chk_pkg.sv
// Shared types for the test-image receive checker.
package test_image_chk_pkg;

   localparam int GEO_W = 12;

   typedef enum logic [3:0] {
      StSync   = 4'b0001,
      StVblank = 4'b0010,
      StHblank = 4'b0100,
      StActive = 4'b1000
   } state_t;

endpackage

// File: rtl/test_image_chk_cnt.sv
// Saturating up-counter; clear and increment in one cycle yields 1.
module test_image_chk_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = clr ? '0 : cnt;
      if (inc && (cnt_d != {W{1'b1}})) begin
         cnt_d = cnt_d + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_d;
      end
   end

endmodule

// File: rtl/test_image_chk.sv
// Receive-side checker for the parallel test-image interface: timing recovery,
// geometry measurement and incrementing-pattern verification.
module test_image_chk
   import test_image_chk_pkg::*;
#(
   parameter int               TCQ      = 100,
   parameter logic [GEO_W-1:0] H_ACTIVE = 12'd257,
   parameter logic [GEO_W-1:0] V_ACTIVE = 12'd256,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic             im_pclk,
   input  logic             rst_n,
   input  logic             im_vsync,
   input  logic             im_hsync,
   input  logic             im_valid,
   input  logic [7:0]       im_dout,
   input  logic             clr,
   output logic             locked,
   output logic             pix_err,
   output logic             line_err,
   output logic             frame_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_frame_cnt,
   output logic [GEO_W-1:0] last_line_len,
   output logic [GEO_W-1:0] last_frame_lines
);

   state_t           state_q, state_d;
   logic             vsync_q;
   logic [7:0]       seed_q, seed_d, exp_q, exp_d, req;
   logic             locked_q, locked_d, skip_q, skip_d, frame_bad_q, frame_bad_d;
   logic             pix_err_q, pix_err_d, line_err_q, line_err_d, frame_err_q, frame_err_d;
   logic             sticky_q, sticky_d;
   logic [GEO_W-1:0] last_len_q, last_len_d, last_lines_q, last_lines_d;
   logic [GEO_W-1:0] pix_cnt, line_cnt, frame_lines;
   logic             vs_rise, vs_fall, live, line_start, line_end, pix_ev, pix_bad;
   logic             frame_end, violation, first_of_frame, any_err;
   logic             unused_tcq;

   assign unused_tcq = (TCQ != 0);

   assign vs_rise        = im_vsync & ~vsync_q;
   assign vs_fall        = ~im_vsync & vsync_q;
   assign live           = (state_q != StSync) & ~clr;
   assign line_start     = live & (state_q == StHblank) & im_valid & ~im_hsync & ~im_vsync;
   assign line_end       = live & (state_q == StActive) & (vs_rise | ~im_valid);
   assign pix_ev         = line_start | (live & (state_q == StActive) & ~vs_rise & im_valid);
   assign frame_end      = live & vs_rise & ((state_q == StHblank) | (state_q == StActive));
   assign violation      = live & ((im_valid & (im_hsync | im_vsync)) |
                                   ((state_q == StActive) & vs_rise));
   assign first_of_frame = line_start & (line_cnt == '0);

   // A line closing on the vsync edge still belongs to the frame that edge ends.
   assign frame_lines = (line_end && (line_cnt != {GEO_W{1'b1}})) ? line_cnt + GEO_W'(1)
                                                                 : line_cnt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSync:   if (vs_fall) state_d = StHblank;
         StVblank: if (vs_fall) state_d = StHblank;
         StHblank: begin
            if (vs_rise) state_d = StVblank;
            else if (im_valid && !im_hsync && !im_vsync) state_d = StActive;
         end
         StActive: begin
            if (vs_rise) state_d = StVblank;
            else if (!im_valid) state_d = StHblank;
         end
         default:  state_d = StSync;
      endcase
      if (clr) state_d = StSync;
   end

   always_comb begin
      req         = line_start ? (first_of_frame ? seed_q + 8'd1 : seed_q) : exp_q;
      pix_bad     = pix_ev & locked_q & ~skip_q & (im_dout != req);
      exp_d       = pix_ev ? im_dout + 8'd1 : exp_q;
      // The pixel after a mismatch is judged against a resynced chain; skip it so
      // a single corrupted pixel gives a single pulse.
      skip_d      = line_end ? 1'b0 : (pix_ev ? pix_bad : skip_q);
      seed_d      = first_of_frame ? im_dout : seed_q;
      locked_d    = locked_q | first_of_frame;
      pix_err_d   = pix_bad;
      line_err_d  = (line_end & (pix_cnt != H_ACTIVE)) | violation;
      frame_err_d = frame_end & (frame_lines != V_ACTIVE);
      any_err     = pix_err_d | line_err_d | frame_err_d;
      sticky_d    = sticky_q | any_err;
      frame_bad_d = frame_end ? 1'b0 : (frame_bad_q | any_err);
      last_len_d  = line_end ? pix_cnt : last_len_q;
      last_lines_d = frame_end ? frame_lines : last_lines_q;
      if (clr) begin
         exp_d        = '0;
         skip_d       = 1'b0;
         seed_d       = '0;
         locked_d     = 1'b0;
         pix_err_d    = 1'b0;
         line_err_d   = 1'b0;
         frame_err_d  = 1'b0;
         sticky_d     = 1'b0;
         frame_bad_d  = 1'b0;
         last_len_d   = '0;
         last_lines_d = '0;
      end
   end

   always_ff @(posedge im_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StSync;
         vsync_q      <= 1'b0;
         seed_q       <= '0;
         exp_q        <= '0;
         locked_q     <= 1'b0;
         skip_q       <= 1'b0;
         frame_bad_q  <= 1'b0;
         pix_err_q    <= 1'b0;
         line_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         sticky_q     <= 1'b0;
         last_len_q   <= '0;
         last_lines_q <= '0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= im_vsync & ~clr;
         seed_q       <= seed_d;
         exp_q        <= exp_d;
         locked_q     <= locked_d;
         skip_q       <= skip_d;
         frame_bad_q  <= frame_bad_d;
         pix_err_q    <= pix_err_d;
         line_err_q   <= line_err_d;
         frame_err_q  <= frame_err_d;
         sticky_q     <= sticky_d;
         last_len_q   <= last_len_d;
         last_lines_q <= last_lines_d;
      end
   end

   test_image_chk_cnt #(.W(GEO_W)) u_pix_cnt (
      .clk(im_pclk), .rst_n(rst_n), .clr(clr | line_start), .inc(pix_ev), .cnt(pix_cnt)
   );

   test_image_chk_cnt #(.W(GEO_W)) u_line_cnt (
      .clk(im_pclk), .rst_n(rst_n), .clr(clr | frame_end | vs_fall),
      .inc(line_end & ~frame_end), .cnt(line_cnt)
   );

   test_image_chk_cnt #(.W(CNT_W)) u_frame_cnt (
      .clk(im_pclk), .rst_n(rst_n), .clr(clr), .inc(frame_end), .cnt(frame_cnt)
   );

   test_image_chk_cnt #(.W(CNT_W)) u_err_frame_cnt (
      .clk(im_pclk), .rst_n(rst_n), .clr(clr), .inc(frame_end & (frame_bad_q | any_err)),
      .cnt(err_frame_cnt)
   );

   assign locked           = locked_q;
   assign pix_err          = pix_err_q;
   assign line_err         = line_err_q;
   assign frame_err        = frame_err_q;
   assign err_sticky       = sticky_q;
   assign last_line_len    = last_len_q;
   assign last_frame_lines = last_lines_q;

endmodule

// File: tb/tb_test_image_chk.sv
// Self-checking bench for test_image_chk on a reduced 9x6 geometry.
module tb_test_image_chk;

   localparam logic [11:0] H  = 12'd9;
   localparam logic [11:0] V  = 12'd6;
   localparam int unsigned CW = 16;

   logic          im_pclk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic          im_vsync = 1'b1, im_hsync = 1'b1, im_valid = 1'b0;
   logic [7:0]    im_dout = 8'h00;
   logic          locked, pix_err, line_err, frame_err, err_sticky;
   logic [CW-1:0] frame_cnt, err_frame_cnt;
   logic [11:0]   last_line_len, last_frame_lines;

   test_image_chk #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
      .im_pclk(im_pclk), .rst_n(rst_n), .im_vsync(im_vsync), .im_hsync(im_hsync),
      .im_valid(im_valid), .im_dout(im_dout), .clr(clr), .locked(locked),
      .pix_err(pix_err), .line_err(line_err), .frame_err(frame_err),
      .err_sticky(err_sticky), .frame_cnt(frame_cnt), .err_frame_cnt(err_frame_cnt),
      .last_line_len(last_line_len), .last_frame_lines(last_frame_lines)
   );

   always #5 im_pclk = ~im_pclk;

   int cyc = 0, tot_pix = 0, tot_line = 0, tot_frame = 0, pix_err_cyc = -1, bad_cyc = -2;
   int n_chk = 0, n_fail = 0;
   int len_a [16];

   always @(posedge im_pclk) cyc <= cyc + 1;

   always @(negedge im_pclk) begin
      if (rst_n) begin
         if (pix_err) begin
            tot_pix     <= tot_pix + 1;
            pix_err_cyc <= cyc;
         end
         if (line_err) tot_line <= tot_line + 1;
         if (frame_err) tot_frame <= tot_frame + 1;
      end
   end

   typedef struct {
      logic [7:0] seed;
      int nl, short_l, short_len, bad_l, bad_i;
      bit viol, trunc;
      int e_pix, e_line, e_ferr, e_fc, e_efc, e_llen, e_llines;
      bit e_sticky;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic vs, hs, v, input logic [7:0] d);
      im_vsync = vs;
      im_hsync = hs;
      im_valid = v;
      im_dout  = d;
      @(posedge im_pclk);
      #1;
   endtask

   task automatic vblank(input int n, input bit do_clr);
      for (int k = 0; k < n; k++) begin
         clr = do_clr && (k == 0);
         drive(1'b1, 1'b1, 1'b0, 8'h00);
      end
      clr = 1'b0;
   endtask

   task automatic set_lens(input int short_l, input int short_len);
      for (int l = 0; l < 16; l++) len_a[l] = int'(H);
      if (short_l >= 0) len_a[short_l] = short_len;
   endtask

   task automatic send_frame(input logic [7:0] seed, input int nl, bad_l, bad_i,
                             input bit viol, trunc);
      logic [7:0] d;
      repeat (2) drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int l = 0; l < nl; l++) begin
         for (int i = 0; i < len_a[l]; i++) begin
            d = seed + 8'(i);
            if (l == bad_l && i == bad_i) d = d ^ 8'h80;
            drive(1'b0, 1'b0, 1'b1, d);
            if (l == bad_l && i == bad_i) bad_cyc = cyc;
            if (l == 0 && i == 0) chk("locked after first pixel", int'(locked), 1);
         end
         if (!(trunc && l == nl - 1)) begin
            repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00);
            if (viol && l == 0) begin
               drive(1'b0, 1'b1, 1'b1, 8'h55);
               drive(1'b0, 1'b1, 1'b0, 8'h00);
            end
         end
      end
   endtask

   task automatic run_frame(input string tag, input logic [7:0] seed, input int nl, bad_l,
                            bad_i, input bit viol, trunc, input int e_pix, e_line, e_ferr,
                            e_fc, e_efc, e_llen, e_llines, input bit e_sticky);
      int p0, l0, f0;
      p0 = tot_pix;
      l0 = tot_line;
      f0 = tot_frame;
      send_frame(seed, nl, bad_l, bad_i, viol, trunc);
      vblank(4, 1'b0);
      chk({tag, " pix_err pulses"}, tot_pix - p0, e_pix);
      chk({tag, " line_err pulses"}, tot_line - l0, e_line);
      chk({tag, " frame_err pulses"}, tot_frame - f0, e_ferr);
      chk({tag, " frame_cnt"}, int'(frame_cnt), e_fc);
      chk({tag, " err_frame_cnt"}, int'(err_frame_cnt), e_efc);
      chk({tag, " last_line_len"}, int'(last_line_len), e_llen);
      chk({tag, " last_frame_lines"}, int'(last_frame_lines), e_llines);
      chk({tag, " locked"}, int'(locked), 1);
      chk({tag, " err_sticky"}, int'(err_sticky), int'(e_sticky));
      if (bad_l >= 0) chk({tag, " pix_err cycle"}, pix_err_cyc, bad_cyc);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " locked"}, int'(locked), 0);
      chk({tag, " pix_err"}, int'(pix_err), 0);
      chk({tag, " line_err"}, int'(line_err), 0);
      chk({tag, " frame_err"}, int'(frame_err), 0);
      chk({tag, " err_sticky"}, int'(err_sticky), 0);
      chk({tag, " frame_cnt"}, int'(frame_cnt), 0);
      chk({tag, " err_frame_cnt"}, int'(err_frame_cnt), 0);
      chk({tag, " last_line_len"}, int'(last_line_len), 0);
      chk({tag, " last_frame_lines"}, int'(last_frame_lines), 0);
   endtask

   initial begin
      vec_t       tbl [10];
      logic [7:0] m_prev, s;
      bit         m_locked, m_sticky, viol, trunc;
      int         m_fc, m_efc, nl, bad_l, bad_i, e_pix, e_line, e_ferr;

      //                seed nl shl shlen badl badi viol trunc pix line ferr fc efc llen lines st
      tbl[0] = '{8'd0,  6, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 0, 1,  0, 9, 6, 1'b0};
      tbl[1] = '{8'd1,  6, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 0, 2,  0, 9, 6, 1'b0};
      tbl[2] = '{8'd2,  6, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 0, 3,  0, 9, 6, 1'b0};
      tbl[3] = '{8'd3,  6, -1, 0,  2, 5, 1'b0, 1'b0, 1, 0, 0, 4,  1, 9, 6, 1'b1};
      tbl[4] = '{8'd4,  6,  5, 8, -1, 0, 1'b0, 1'b0, 0, 1, 0, 5,  2, 8, 6, 1'b1};
      tbl[5] = '{8'd5,  5, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 1, 6,  3, 9, 5, 1'b1};
      tbl[6] = '{8'd7,  6, -1, 0, -1, 0, 1'b0, 1'b0, 1, 0, 0, 7,  4, 9, 6, 1'b1};
      tbl[7] = '{8'd8,  6, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 0, 8,  4, 9, 6, 1'b1};
      tbl[8] = '{8'd9,  6, -1, 0, -1, 0, 1'b1, 1'b0, 0, 1, 0, 9,  5, 9, 6, 1'b1};
      tbl[9] = '{8'd10, 6, -1, 0, -1, 0, 1'b0, 1'b1, 0, 1, 0, 10, 6, 9, 6, 1'b1};

      repeat (3) @(posedge im_pclk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      vblank(3, 1'b0);

      foreach (tbl[i]) begin
         set_lens(tbl[i].short_l, tbl[i].short_len);
         run_frame($sformatf("vec%0d", i), tbl[i].seed, tbl[i].nl, tbl[i].bad_l,
                   tbl[i].bad_i, tbl[i].viol, tbl[i].trunc, tbl[i].e_pix, tbl[i].e_line,
                   tbl[i].e_ferr, tbl[i].e_fc, tbl[i].e_efc, tbl[i].e_llen,
                   tbl[i].e_llines, tbl[i].e_sticky);
      end

      // Asynchronous reset in the middle of a line; the rest of that frame is ignored.
      set_lens(-1, 0);
      repeat (2) drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 8'(11 + i));
      rst_n = 1'b0;
      #1;
      check_zero("async reset");
      drive(1'b0, 1'b0, 1'b1, 8'd15);
      drive(1'b0, 1'b0, 1'b1, 8'd16);
      rst_n = 1'b1;
      for (int i = 6; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 8'(11 + i));
      for (int l = 0; l < 5; l++) begin
         repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00);
         for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 8'(11 + i));
      end
      repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00);
      vblank(4, 1'b0);
      chk("partial frame not counted", int'(frame_cnt), 0);
      chk("partial frame not locked", int'(locked), 0);
      run_frame("relock", 8'd50, 6, -1, 0, 1'b0, 1'b0, 0, 0, 0, 1, 0, 9, 6, 1'b0);

      // clr on the vsync rising edge wins over the frame end.
      send_frame(8'd51, 6, -1, 0, 1'b0, 1'b0);
      vblank(4, 1'b1);
      check_zero("clr");
      run_frame("after clr", 8'd99, 6, -1, 0, 1'b0, 1'b0, 0, 0, 0, 1, 0, 9, 6, 1'b0);

      // Randomized frames against a frame-level model.
      m_locked = 1'b1;
      m_prev   = 8'd99;
      m_fc     = 1;
      m_efc    = 0;
      m_sticky = 1'b0;
      for (int f = 0; f < 16; f++) begin
         nl = $urandom_range(7, 5);
         for (int l = 0; l < 16; l++) begin
            case ($urandom_range(9, 0))
               0:       len_a[l] = int'(H) - 1;
               1:       len_a[l] = int'(H) + 1;
               default: len_a[l] = int'(H);
            endcase
         end
         s = m_prev + 8'd1;
         if ($urandom_range(3, 0) == 0) s = 8'($urandom);
         bad_l = -1;
         bad_i = 0;
         if ($urandom_range(2, 0) == 0) begin
            bad_l = $urandom_range(nl - 1, 1);
            bad_i = $urandom_range(len_a[bad_l] - 1, 0);
         end
         viol  = ($urandom_range(5, 0) == 0);
         trunc = ($urandom_range(5, 0) == 0);

         e_pix = ((m_locked && s != m_prev + 8'd1) ? 1 : 0) + ((bad_l >= 0) ? 1 : 0);
         e_line = viol ? 1 : 0;
         for (int l = 0; l < nl; l++) begin
            if (len_a[l] != int'(H) || (trunc && l == nl - 1)) e_line++;
         end
         e_ferr = (nl != int'(V)) ? 1 : 0;
         m_fc++;
         if (e_pix + e_line + e_ferr > 0) begin
            m_efc++;
            m_sticky = 1'b1;
         end
         m_prev   = s;
         m_locked = 1'b1;
         run_frame($sformatf("rand%0d", f), s, nl, bad_l, bad_i, viol, trunc, e_pix, e_line,
                   e_ferr, m_fc, m_efc, len_a[nl - 1], nl, m_sticky);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
